data_stack: RTL and testbench

Operand stack for the 16-bit stack processor. It holds the top two entries in registers (`top_of_stack`, `second_of_stack`) that feed the ALU and branch compare directly, and spills deeper entries to an internal RAM. The decode stage issues one stack operation per cycle. ALU results come back on `din`. Every operation completes in a single cycle, with no stalls.

---
 rtl/data_stack.sv | 156 +++++++++++++++
 tb/tb_data_stack.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// Operand stack for the 16-bit stack processor: top two entries live in registers,
// deeper entries spill to a RAM with synchronous write and asynchronous read.
module data_stack #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 7
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic [15:0]       din,
    output logic [15:0]       top_of_stack,
    output logic [15:0]       second_of_stack,
    output logic [CNT_W-1:0]  depth,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_PUSH    = 3'b001,
        OP_DROP    = 3'b010,
        OP_DUP     = 3'b011,
        OP_OVER    = 3'b100,
        OP_SWAP    = 3'b101,
        OP_BINOP   = 3'b110,
        OP_REPLACE = 3'b111
    } op_t;

    localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH + 2);
    localparam logic [CNT_W-1:0] C0  = CNT_W'(0);
    localparam logic [CNT_W-1:0] C1  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C2  = CNT_W'(2);
    localparam logic [CNT_W-1:0] C3  = CNT_W'(3);

    logic [15:0]        ram [DEPTH];
    logic [15:0]        tos_q, nos_q, tos_d, nos_d;
    logic [CNT_W-1:0]   depth_q, depth_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               ram_we;
    logic [CNT_W-1:0]   sp_wide;
    logic [ADDR_W-1:0]  sp, rd_addr;
    logic [15:0]        refill, push_val;
    logic               is_full;
    op_t                op_e;

    assign op_e    = op_t'(op);
    assign is_full = (depth_q == MAX);
    assign sp_wide = (depth_q >= C2) ? depth_q - C2 : C0;
    assign sp      = sp_wide[ADDR_W-1:0];
    assign rd_addr = sp - ADDR_W'(1);
    // rd_addr is only meaningful (and in range) once a third entry exists
    assign refill  = (depth_q >= C3) ? ram[rd_addr] : 16'h0000;

    always_comb begin
        tos_d    = tos_q;
        nos_d    = nos_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ram_we   = 1'b0;
        push_val = 16'h0000;
        if (en) begin
            case (op_e)
                OP_PUSH, OP_DUP, OP_OVER: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        if (op_e == OP_PUSH) begin
                            push_val = din;
                        end else if (op_e == OP_DUP) begin
                            if (depth_q == C0) unf_d = 1'b1;
                            else               push_val = tos_q;
                        end else begin
                            if (depth_q < C2) unf_d = 1'b1;
                            else              push_val = nos_q;
                        end
                        ram_we  = (depth_q >= C2);
                        nos_d   = tos_q;
                        tos_d   = push_val;
                        depth_d = depth_q + C1;
                    end
                end
                OP_DROP: begin
                    if (depth_q == C0) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = nos_q;
                        nos_d   = refill;
                        depth_d = depth_q - C1;
                    end
                end
                OP_BINOP: begin
                    tos_d = din;
                    if (depth_q < C2) begin
                        unf_d   = 1'b1;
                        nos_d   = 16'h0000;
                        depth_d = C1;
                    end else begin
                        nos_d   = refill;
                        depth_d = depth_q - C1;
                    end
                end
                OP_SWAP: begin
                    if (depth_q < C2) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                OP_REPLACE: begin
                    tos_d = din;
                    if (depth_q == C0) begin
                        unf_d   = 1'b1;
                        depth_d = C1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            tos_q   <= 16'h0000;
            nos_q   <= 16'h0000;
            depth_q <= C0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // RAM contents survive reset; they are unreachable until rewritten
    always_ff @(posedge CLK) begin
        if (!reset && ram_we) ram[sp] <= nos_q;
    end

    assign top_of_stack    = tos_q;
    assign second_of_stack = nos_q;
    assign depth           = depth_q;
    assign empty           = (depth_q == C0);
    assign full            = is_full;
    assign overflow        = ovf_q;
    assign underflow       = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Randomized bench for data_stack against a queue-based stack model, plus directed scenarios.
module tb_data_stack;

    localparam int DEPTH = 64;
    localparam int MAX   = DEPTH + 2;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3,
                           OVER = 3'd4, SWAP = 3'd5, BINOP = 3'd6, REPL = 3'd7;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] din = 16'h0;
    logic [15:0] top_of_stack, second_of_stack;
    logic [6:0]  depth;
    logic        empty, full, overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] stk[$];   // stk[0] is the top of the stack
    bit m_ovf, m_unf;

    data_stack #(.DEPTH(DEPTH), .ADDR_W(6), .CNT_W(7)) dut (
        .CLK(CLK), .reset(reset), .en(en), .op(op), .din(din),
        .top_of_stack(top_of_stack), .second_of_stack(second_of_stack),
        .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_apply(input bit r, input bit e, input logic [2:0] o, input logic [15:0] d);
        logic [15:0] v, t;
        int n;
        n = stk.size();
        if (r) begin
            stk = {};
            m_ovf = 0;
            m_unf = 0;
        end else if (e) begin
            case (o)
                PUSH, DUP, OVER: begin
                    if (n == MAX) m_ovf = 1;
                    else begin
                        if (o == PUSH) v = d;
                        else if (o == DUP) begin
                            v = (n >= 1) ? stk[0] : 16'h0;
                            if (n == 0) m_unf = 1;
                        end else begin
                            v = (n >= 2) ? stk[1] : 16'h0;
                            if (n < 2) m_unf = 1;
                        end
                        stk.push_front(v);
                    end
                end
                DROP: if (n == 0) m_unf = 1; else void'(stk.pop_front());
                BINOP: begin
                    if (n < 2) begin
                        m_unf = 1;
                        stk = {};
                    end else begin
                        void'(stk.pop_front());
                        void'(stk.pop_front());
                    end
                    stk.push_front(d);
                end
                SWAP: begin
                    if (n < 2) m_unf = 1;
                    else begin
                        t = stk[0];
                        stk[0] = stk[1];
                        stk[1] = t;
                    end
                end
                REPL: begin
                    if (n == 0) begin
                        m_unf = 1;
                        stk.push_front(d);
                    end else stk[0] = d;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        n = stk.size();
        check({tag, ".tos"},   32'(top_of_stack),    32'((n >= 1) ? stk[0] : 16'h0));
        check({tag, ".nos"},   32'(second_of_stack), 32'((n >= 2) ? stk[1] : 16'h0));
        check({tag, ".depth"}, 32'(depth),           32'(n));
        check({tag, ".empty"}, 32'(empty),           32'(n == 0));
        check({tag, ".full"},  32'(full),            32'(n == MAX));
        check({tag, ".ovf"},   32'(overflow),        32'(m_ovf));
        check({tag, ".unf"},   32'(underflow),       32'(m_unf));
    endtask

    // drive one cycle, advance model, sample 1 time unit after the edge
    task automatic step(input bit r, input bit e, input logic [2:0] o, input logic [15:0] d, input string tag);
        reset = r;
        en    = e;
        op    = o;
        din   = d;
        @(posedge CLK);
        model_apply(r, e, o, d);
        #1;
        compare_model(tag);
    endtask

    task automatic op1(input logic [2:0] o, input logic [15:0] d);
        step(1'b0, 1'b1, o, d, "dir");
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, NOP, 16'h0, "rst");
    endtask

    initial begin
        int bias;
        int r;
        logic [2:0] o;
        m_ovf = 0;
        m_unf = 0;
        #2;
        do_reset();
        check("reset_depth", 32'(depth), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);

        // spill then BINOP refill from RAM
        op1(PUSH, 1); op1(PUSH, 2); op1(PUSH, 3); op1(BINOP, 5);
        check("p1_tos", 32'(top_of_stack), 32'd5);
        check("p1_nos", 32'(second_of_stack), 32'd1);
        check("p1_depth", 32'(depth), 32'd2);

        do_reset();
        op1(PUSH, 1); op1(PUSH, 2); op1(OVER, 0); op1(DUP, 0);
        check("p2_tos", 32'(top_of_stack), 32'd1);
        check("p2_nos", 32'(second_of_stack), 32'd1);
        check("p2_depth", 32'(depth), 32'd4);
        op1(DROP, 0); op1(DROP, 0); op1(DROP, 0);
        check("p2_drop_tos", 32'(top_of_stack), 32'd1);
        check("p2_drop_nos", 32'(second_of_stack), 32'd0);

        do_reset();
        op1(PUSH, 1); op1(PUSH, 2); op1(PUSH, 3); op1(SWAP, 0); op1(DROP, 0);
        check("p3_tos", 32'(top_of_stack), 32'd3);
        check("p3_nos", 32'(second_of_stack), 32'd1);

        // fill to capacity, overflow, then drain
        do_reset();
        for (int i = 0; i < MAX; i++) op1(PUSH, 16'(i));
        check("p4_full", 32'(full), 32'd1);
        check("p4_tos", 32'(top_of_stack), 32'd65);
        op1(PUSH, 99);
        check("p4_ovf", 32'(overflow), 32'd1);
        check("p4_ovf_tos", 32'(top_of_stack), 32'd65);
        for (int i = 0; i < MAX; i++) begin
            check("p4_pop_seq", 32'(top_of_stack), 32'(65 - i));
            op1(DROP, 0);
        end
        check("p4_empty", 32'(empty), 32'd1);

        do_reset();
        op1(DROP, 0);
        check("p5_unf", 32'(underflow), 32'd1);
        op1(PUSH, 7);
        check("p5_tos", 32'(top_of_stack), 32'd7);
        check("p5_unf_sticky", 32'(underflow), 32'd1);
        op1(SWAP, 0);

        do_reset();
        op1(PUSH, 4);
        step(1'b1, 1'b1, PUSH, 16'd5, "rst_mid");
        check("p6_depth", 32'(depth), 32'd0);
        op1(REPL, 16'd4096);
        check("p6_tos", 32'(top_of_stack), 32'd4096);
        check("p6_unf", 32'(underflow), 32'd1);

        // randomized mix with alternating fill/drain bias
        bias = 80;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) bias = (bias == 80) ? 25 : 80;
            r = $urandom_range(99);
            if (r < bias) o = 3'($urandom_range(2)) + ((r % 3 == 0) ? PUSH : (r % 3 == 1) ? DUP : OVER) - 3'($urandom_range(2));
            else begin
                case ($urandom_range(4))
                    0: o = DROP;
                    1: o = BINOP;
                    2: o = SWAP;
                    3: o = REPL;
                    default: o = NOP;
                endcase
            end
            if (r < bias) begin
                case (r % 3)
                    0: o = PUSH;
                    1: o = DUP;
                    default: o = OVER;
                endcase
            end
            step(($urandom_range(199) == 0), ($urandom_range(19) != 0), o, 16'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
